// File: rtl/baby_kyber_encrypt.sv
// Baby-Kyber encryption engine: u = A^T*r + e1, v = t^T*r + e2 + ceil(Q/2)*m over Z_Q[x]/(x^N+1).
// One shared multiply-accumulate step per cycle, sequenced by an IDLE/LOAD/MAC/ADD FSM.
module baby_kyber_encrypt #(
  parameter int Q = 17,
  parameter int N = 4,
  parameter int K = 2,
  parameter int W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [K*K*N*W-1:0] pk_a,
  input  logic [K*N*W-1:0]   pk_t,
  input  logic [K*N*W-1:0]   r_vec,
  input  logic [K*N*W-1:0]   e1_vec,
  input  logic [N*W-1:0]     e2_poly,
  input  logic [N-1:0]       msg,
  output logic               busy,
  output logic               done,
  output logic [K*N*W-1:0]   u_out,
  output logic [N*W-1:0]     v_out
);

  localparam int CW  = $clog2(Q);
  localparam int PW  = 2 * CW;
  localparam int NA  = K * K * N;
  localparam int NV  = K * N;
  localparam int PCW = $clog2(K + 1);
  localparam int JCW = (K > 1) ? $clog2(K) : 1;
  localparam int ICW = (N > 1) ? $clog2(N) : 1;

  localparam logic [PCW-1:0]       P_LAST = PCW'(K);
  localparam logic [JCW-1:0]       J_LAST = JCW'(K - 1);
  localparam logic [ICW-1:0]       I_LAST = ICW'(N - 1);
  localparam logic [ICW:0]         D_N    = (ICW + 1)'(N);
  localparam logic [CW:0]          Q1     = (CW + 1)'(Q);
  localparam logic [CW+1:0]        Q2     = (CW + 2)'(Q);
  localparam logic [CW+1:0]        HALF   = (CW + 2)'((Q + 1) / 2);
  localparam logic signed [W-1:0]  QS     = W'(Q);

  // Signed input word to canonical residue 0..Q-1; used once per word in LOAD.
  function automatic logic [CW-1:0] reduce_word(input logic [W-1:0] x);
    logic signed [W-1:0] rem;
    rem = $signed(x) % QS;
    if (rem < 0) rem = rem + QS;
    return CW'(rem);
  endfunction

  // Restoring shift-subtract reduction of a product below Q*Q, no divider.
  function automatic logic [CW-1:0] mod_prod(input logic [PW-1:0] x);
    logic [PW-1:0] y;
    y = x;
    for (int s = PW - CW; s >= 0; s--) begin
      if (y >= (PW'(Q) << s)) y = y - (PW'(Q) << s);
    end
    return CW'(y);
  endfunction

  function automatic logic [CW-1:0] add_mod(input logic [CW-1:0] a, input logic [CW-1:0] b);
    logic [CW:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= Q1) s = s - Q1;
    return CW'(s);
  endfunction

  function automatic logic [CW-1:0] sub_mod(input logic [CW-1:0] a, input logic [CW-1:0] b);
    logic [CW:0] s;
    if (a >= b) s = {1'b0, a} - {1'b0, b};
    else        s = {1'b0, a} + Q1 - {1'b0, b};
    return CW'(s);
  endfunction

  function automatic logic [CW-1:0] add_mod3(input logic [CW-1:0] a, input logic [CW-1:0] b,
                                             input logic m);
    logic [CW+1:0] s;
    s = {2'b00, a} + {2'b00, b} + (m ? HALF : '0);
    if (s >= Q2) s = s - Q2;
    if (s >= Q2) s = s - Q2;
    return CW'(s);
  endfunction

  typedef enum logic [1:0] {IDLE, LOAD, MAC, ADD} state_t;
  state_t state_reg, state_next;

  logic cap_en, load_en, mac_en, add_en;

  logic [NA*W-1:0]          a_raw;
  logic [NV*W-1:0]          t_raw, r_raw, e1_raw;
  logic [N*W-1:0]           e2_raw;
  logic [N-1:0]             msg_raw;
  logic [NA*CW-1:0]         a_red, a_red_next;
  logic [NV*CW-1:0]         t_red, t_red_next, r_red, r_red_next, e1_red, e1_red_next;
  logic [N*CW-1:0]          e2_red, e2_red_next;
  logic [(K+1)*N*CW-1:0]    acc;
  logic [NV*CW-1:0]         u_reg, u_next;
  logic [N*CW-1:0]          v_reg, v_next;

  logic [PCW-1:0] p_cnt, p_next, p_sel;
  logic [JCW-1:0] j_cnt, j_next;
  logic [ICW-1:0] i_cnt, i_next, k_cnt, k_next, dm;
  logic [ICW:0]   d;
  logic           wrap, i_wrap, j_wrap, mac_last;
  logic [CW-1:0]  a_coef, b_coef, pm, acc_cur, acc_new;
  logic [PW-1:0]  prod;
  int             a_idx, t_idx, r_idx, acc_idx;

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // FSM: next state
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = LOAD;
      LOAD:    state_next = MAC;
      MAC:     if (mac_last) state_next = ADD;
      ADD:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM: outputs and datapath enables
  always_comb begin
    busy    = (state_reg != IDLE);
    cap_en  = (state_reg == IDLE) && start;
    load_en = (state_reg == LOAD);
    mac_en  = (state_reg == MAC);
    add_en  = (state_reg == ADD);
  end

  genvar gi;
  generate
    for (gi = 0; gi < NA; gi++) begin : g_red_a
      assign a_red_next[gi*CW +: CW] = reduce_word(a_raw[gi*W +: W]);
    end
    for (gi = 0; gi < NV; gi++) begin : g_vec
      assign t_red_next[gi*CW +: CW]  = reduce_word(t_raw[gi*W +: W]);
      assign r_red_next[gi*CW +: CW]  = reduce_word(r_raw[gi*W +: W]);
      assign e1_red_next[gi*CW +: CW] = reduce_word(e1_raw[gi*W +: W]);
      assign u_next[gi*CW +: CW]      = add_mod(acc[gi*CW +: CW], e1_red[gi*CW +: CW]);
      assign u_out[gi*W +: W]         = {{(W-CW){1'b0}}, u_reg[gi*CW +: CW]};
    end
    for (gi = 0; gi < N; gi++) begin : g_poly
      assign e2_red_next[gi*CW +: CW] = reduce_word(e2_raw[gi*W +: W]);
      assign v_next[gi*CW +: CW]      = add_mod3(acc[(K*N+gi)*CW +: CW], e2_red[gi*CW +: CW],
                                                 msg_raw[gi]);
      assign v_out[gi*W +: W]         = {{(W-CW){1'b0}}, v_reg[gi*CW +: CW]};
    end
  endgenerate

  // Operand fetch, product, negacyclic accumulate and counter advance for one MAC step.
  always_comb begin
    p_sel   = (p_cnt == P_LAST) ? '0 : p_cnt;
    a_idx   = (int'(j_cnt) * K + int'(p_sel)) * N + int'(i_cnt);
    t_idx   = int'(j_cnt) * N + int'(i_cnt);
    r_idx   = int'(j_cnt) * N + int'(k_cnt);
    a_coef  = (p_cnt == P_LAST) ? t_red[t_idx*CW +: CW] : a_red[a_idx*CW +: CW];
    b_coef  = r_red[r_idx*CW +: CW];
    prod    = PW'(a_coef) * PW'(b_coef);
    pm      = mod_prod(prod);
    d       = {1'b0, i_cnt} + {1'b0, k_cnt};
    wrap    = (d >= D_N);
    dm      = wrap ? ICW'(d - D_N) : ICW'(d);
    acc_idx = int'(p_cnt) * N + int'(dm);
    acc_cur = acc[acc_idx*CW +: CW];
    acc_new = wrap ? sub_mod(acc_cur, pm) : add_mod(acc_cur, pm);

    k_next   = (k_cnt == I_LAST) ? '0 : k_cnt + 1'b1;
    i_wrap   = (k_cnt == I_LAST) && (i_cnt == I_LAST);
    i_next   = (k_cnt != I_LAST) ? i_cnt : (i_wrap ? '0 : i_cnt + 1'b1);
    j_wrap   = i_wrap && (j_cnt == J_LAST);
    j_next   = !i_wrap ? j_cnt : (j_wrap ? '0 : j_cnt + 1'b1);
    mac_last = j_wrap && (p_cnt == P_LAST);
    p_next   = !j_wrap ? p_cnt : (mac_last ? '0 : p_cnt + 1'b1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_raw   <= '0;
      t_raw   <= '0;
      r_raw   <= '0;
      e1_raw  <= '0;
      e2_raw  <= '0;
      msg_raw <= '0;
      a_red   <= '0;
      t_red   <= '0;
      r_red   <= '0;
      e1_red  <= '0;
      e2_red  <= '0;
      acc     <= '0;
      u_reg   <= '0;
      v_reg   <= '0;
      p_cnt   <= '0;
      j_cnt   <= '0;
      i_cnt   <= '0;
      k_cnt   <= '0;
      done    <= 1'b0;
    end else begin
      done <= add_en;
      if (cap_en) begin
        a_raw   <= pk_a;
        t_raw   <= pk_t;
        r_raw   <= r_vec;
        e1_raw  <= e1_vec;
        e2_raw  <= e2_poly;
        msg_raw <= msg;
      end
      if (load_en) begin
        a_red  <= a_red_next;
        t_red  <= t_red_next;
        r_red  <= r_red_next;
        e1_red <= e1_red_next;
        e2_red <= e2_red_next;
        acc    <= '0;
        p_cnt  <= '0;
        j_cnt  <= '0;
        i_cnt  <= '0;
        k_cnt  <= '0;
      end
      if (mac_en) begin
        acc[acc_idx*CW +: CW] <= acc_new;
        p_cnt <= p_next;
        j_cnt <= j_next;
        i_cnt <= i_next;
        k_cnt <= k_next;
      end
      if (add_en) begin
        u_reg <= u_next;
        v_reg <= v_next;
      end
    end
  end

endmodule

// File: tb/tb_baby_kyber_encrypt.sv
// Scoreboard bench for baby_kyber_encrypt: directed plus randomized encryptions checked
// against a polynomial-arithmetic reference model.
module tb_baby_kyber_encrypt;
  localparam int Q   = 17;
  localparam int N   = 4;
  localparam int K   = 2;
  localparam int W   = 32;
  localparam int LAT = 2 + (K + 1) * K * N * N;
  localparam int UW  = K * N * W;
  localparam int VW  = N * W;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic [K*K*N*W-1:0] pk_a = '0;
  logic [UW-1:0]   pk_t = '0, r_vec = '0, e1_vec = '0;
  logic [VW-1:0]   e2_poly = '0;
  logic [N-1:0]    msg = '0;
  logic            busy, done;
  logic [UW-1:0]   u_out;
  logic [VW-1:0]   v_out;

  baby_kyber_encrypt #(.Q(Q), .N(N), .K(K), .W(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pk_a(pk_a), .pk_t(pk_t),
    .r_vec(r_vec), .e1_vec(e1_vec), .e2_poly(e2_poly), .msg(msg),
    .busy(busy), .done(done), .u_out(u_out), .v_out(v_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int a_in [K][K][N];
  int t_in [K][N];
  int r_in [K][N];
  int e1_in[K][N];
  int e2_in[N];
  logic [N-1:0] msg_in;

  logic [UW-1:0] exp_u_q[$];
  logic [VW-1:0] exp_v_q[$];
  int            exp_cyc_q[$];

  int n_tests = 0;
  int n_fail  = 0;
  int n_done  = 0;

  function automatic int md(int x);
    return ((x % Q) + Q) % Q;
  endfunction

  function automatic int rv();
    if ($urandom_range(0, 3) == 0) return int'($urandom);
    return int'($urandom_range(0, 40)) - 20;
  endfunction

  function automatic logic [VW-1:0] pack4(int c0, int c1, int c2, int c3);
    logic [VW-1:0] p;
    p = '0;
    p[0*W +: W] = c0;
    p[1*W +: W] = c1;
    p[2*W +: W] = c2;
    p[3*W +: W] = c3;
    return p;
  endfunction

  task automatic check_vec(input string name, input logic [UW-1:0] act, input logic [UW-1:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end else begin
      $display("[TB] ok %s = %h", name, act);
    end
  endtask

  task automatic clear_inputs();
    for (int j = 0; j < K; j++)
      for (int c = 0; c < N; c++) begin
        for (int i = 0; i < K; i++) a_in[j][i][c] = 0;
        t_in[j][c] = 0; r_in[j][c] = 0; e1_in[j][c] = 0;
      end
    for (int c = 0; c < N; c++) e2_in[c] = 0;
    msg_in = '0;
  endtask

  task automatic random_inputs();
    for (int j = 0; j < K; j++)
      for (int c = 0; c < N; c++) begin
        for (int i = 0; i < K; i++) a_in[j][i][c] = rv();
        t_in[j][c] = rv(); r_in[j][c] = rv(); e1_in[j][c] = rv();
      end
    for (int c = 0; c < N; c++) e2_in[c] = rv();
    msg_in = N'($urandom);
  endtask

  // u[p] = sum_j A[j][p]*r[j] + e1[p], v = sum_j t[j]*r[j] + e2 + ceil(Q/2)*m, in Z_Q[x]/(x^N+1)
  task automatic model(output logic [UW-1:0] eu, output logic [VW-1:0] ev);
    int acc[N];
    int a, b;
    eu = '0;
    ev = '0;
    for (int p = 0; p <= K; p++) begin
      for (int c = 0; c < N; c++) acc[c] = 0;
      for (int j = 0; j < K; j++)
        for (int i = 0; i < N; i++)
          for (int k = 0; k < N; k++) begin
            a = (p < K) ? md(a_in[j][p][i]) : md(t_in[j][i]);
            b = md(r_in[j][k]);
            if (i + k < N) acc[i + k] += a * b;
            else           acc[i + k - N] -= a * b;
          end
      for (int c = 0; c < N; c++) begin
        if (p < K) eu[(p*N + c)*W +: W] = md(acc[c] + md(e1_in[p][c]));
        else       ev[c*W +: W] = md(acc[c] + md(e2_in[c]) + (msg_in[c] ? (Q + 1) / 2 : 0));
      end
    end
  endtask

  // Called just after a negedge; drives start for one cycle.
  task automatic drive_start(input bit accept);
    logic [UW-1:0] eu;
    logic [VW-1:0] ev;
    for (int j = 0; j < K; j++)
      for (int c = 0; c < N; c++) begin
        for (int i = 0; i < K; i++) pk_a[((j*K + i)*N + c)*W +: W] = a_in[j][i][c];
        pk_t[(j*N + c)*W +: W]   = t_in[j][c];
        r_vec[(j*N + c)*W +: W]  = r_in[j][c];
        e1_vec[(j*N + c)*W +: W] = e1_in[j][c];
      end
    for (int c = 0; c < N; c++) e2_poly[c*W +: W] = e2_in[c];
    msg = msg_in;
    if (accept) begin
      model(eu, ev);
      exp_u_q.push_back(eu);
      exp_v_q.push_back(ev);
      exp_cyc_q.push_back(cyc + 1 + LAT);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_result(input string name);
    for (int n = 0; n < LAT + 20 && exp_u_q.size() != 0; n++) @(negedge clk);
    if (exp_u_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: got no done within %0d cycles, required done", name, LAT + 20);
      exp_u_q.delete();
      exp_v_q.delete();
      exp_cyc_q.delete();
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT signals a result.
  always @(negedge clk) begin
    if (rst_n && done) begin
      n_done++;
      if (exp_u_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_done: got done at cycle %0d, required none", cyc);
      end else begin
        logic [UW-1:0] eu;
        logic [VW-1:0] ev;
        int ec;
        eu = exp_u_q.pop_front();
        ev = exp_v_q.pop_front();
        ec = exp_cyc_q.pop_front();
        check_vec("u_out", u_out, eu);
        check_vec("v_out", UW'(v_out), UW'(ev));
        n_tests++;
        if (cyc != ec) begin
          n_fail++;
          $display("FAIL latency: got done at cycle %0d required %0d", cyc, ec);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int done_before;
    clear_inputs();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_vec("reset_busy", UW'(busy), '0);
    check_vec("reset_done", UW'(done), '0);
    check_vec("reset_u", u_out, '0);
    check_vec("reset_v", UW'(v_out), '0);
    rst_n = 1'b1;
    @(negedge clk);

    // all zero, msg all ones
    clear_inputs();
    msg_in = 4'b1111;
    drive_start(1);
    check_vec("busy_after_start", UW'(busy), UW'(1));
    wait_result("zero_msg");
    check_vec("zero_msg_v", UW'(v_out), UW'(pack4(9, 9, 9, 9)));

    // negacyclic wrap
    clear_inputs();
    a_in[0][0] = '{1, 2, 3, 4};
    r_in[0][1] = 1;
    drive_start(1);
    wait_result("wrap");
    check_vec("wrap_u0", UW'(u_out[VW-1:0]), UW'(pack4(13, 1, 2, 3)));

    // negative and oversize inputs
    clear_inputs();
    e1_in[0] = '{-1, -17, 17, 33};
    drive_start(1);
    wait_result("neg_in");
    check_vec("neg_in_u0", UW'(u_out[VW-1:0]), UW'(pack4(16, 0, 0, 16)));

    // largest product plus message offset
    clear_inputs();
    t_in[0] = '{16, 16, 16, 16};
    r_in[0][0] = -1;
    msg_in = 4'b0001;
    drive_start(1);
    wait_result("max_prod");
    check_vec("max_prod_v", UW'(v_out), UW'(pack4(10, 1, 1, 1)));

    // start while busy is ignored; start in the done cycle is accepted
    done_before = n_done;
    random_inputs();
    drive_start(1);
    repeat (9) @(negedge clk);
    random_inputs();
    drive_start(0);
    for (int n = 0; n < LAT + 20 && !done; n++) @(negedge clk);
    random_inputs();
    drive_start(1);
    check_vec("busy_after_done_start", UW'(busy), UW'(1));
    wait_result("back_to_back");
    repeat (3) @(negedge clk);
    check_vec("done_count", UW'(n_done - done_before), UW'(2));

    // reset in the middle of MAC
    clear_inputs();
    a_in[0][0] = '{1, 2, 3, 4};
    r_in[0][1] = 1;
    drive_start(1);
    repeat (41) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_vec("abort_busy", UW'(busy), '0);
    check_vec("abort_done", UW'(done), '0);
    check_vec("abort_u", u_out, '0);
    check_vec("abort_v", UW'(v_out), '0);
    exp_u_q.delete();
    exp_v_q.delete();
    exp_cyc_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    drive_start(1);
    wait_result("after_abort");
    check_vec("after_abort_u0", UW'(u_out[VW-1:0]), UW'(pack4(13, 1, 2, 3)));

    // randomized encryptions
    for (int t = 0; t < 20; t++) begin
      random_inputs();
      drive_start(1);
      wait_result("random");
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    check_vec("scoreboard_empty", UW'(exp_u_q.size()), '0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
